// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
// CPU-side load/store request/response bundle for dmem_access_unit.
//   req_read / req_write : load / store request, held by the CPU until done
//   req_addr             : byte address
//   req_size             : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         : loads only, 1 = zero-extend, 0 = sign-extend
//   req_wdata            : store data, right-aligned for sub-word stores
//   busy                 : CPU stall
//   done                 : one-cycle completion pulse
//   resp_rdata           : extended load result, valid while done = 1
//   err                  : misaligned/illegal flag, valid while done = 1
// master = CPU execute stage, slave = access unit.
// ---------------------------------------------------------------------------
interface dmem_access_unit_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] resp_rdata;
    logic        err;

    modport master (
        output req_read, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  busy, done, resp_rdata, err
    );

    modport slave (
        input  req_read, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output busy, done, resp_rdata, err
    );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// Load/store front end between the CPU execute stage and a word-wide RAM.
// Byte/half/word loads and stores are turned into whole-word RAM accesses;
// sub-word stores are done as read-modify-write. The CPU is stalled while an
// access is in flight, and misaligned or illegal requests complete with err.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cpu               : request/response bundle (slave side)
//   ram_read_enable   : RAM read strobe
//   ram_write_enable  : RAM write strobe
//   ram_address       : RAM word address (0 when idle)
//   ram_data_in       : full word written to RAM (0 when not writing)
//   ram_data_out      : registered RAM read data, valid the cycle after read
// ---------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_access_unit_if.slave     cpu,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data_in,
    input  logic [31:0]           ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DONE
    } state_t;

    state_t state, state_next;

    // Only the byte-address bits that reach the RAM are kept; the rest wrap.
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  store_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged_q;
    logic [31:0]           resp_rdata_q;
    logic                  err_q;

    logic                  req_any;
    logic                  req_illegal;
    logic [4:0]            lane_shift;
    logic [15:0]           lane_half;
    logic [31:0]           load_value;
    logic [31:0]           lane_width_mask;
    logic [31:0]           merged_value;

    assign req_any = cpu.req_read || cpu.req_write;

    // Conflicting strobes, the reserved size code and misaligned half/word
    // accesses are all rejected without touching the RAM.
    assign req_illegal = (cpu.req_read && cpu.req_write)
                      || (cpu.req_size == 2'b11)
                      || (cpu.req_size == 2'b01 && cpu.req_addr[0])
                      || (cpu.req_size == 2'b10 && cpu.req_addr[1:0] != 2'b00);

    // Little-endian lane select: byte offset times eight is the bit shift.
    assign lane_shift = {addr_q[1:0], 3'b000};
    assign lane_half  = 16'(ram_data_out >> lane_shift);

    always_comb begin
        load_value = ram_data_out;
        case (size_q)
            2'b00:   load_value = uns_q ? {24'h0, lane_half[7:0]}
                                        : {{24{lane_half[7]}}, lane_half[7:0]};
            2'b01:   load_value = uns_q ? {16'h0, lane_half}
                                        : {{16{lane_half[15]}}, lane_half};
            default: load_value = ram_data_out;
        endcase
    end

    // Read-modify-write merge: clear the addressed lane of the fetched word
    // and drop the right-aligned store data into it.
    assign lane_width_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign merged_value    = (ram_data_out & ~(lane_width_mask << lane_shift))
                           | ((wdata_q & lane_width_mask) << lane_shift);

    // Next-state logic. Requests are only looked at in IDLE, so a request
    // still held during DONE is not taken a second time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (req_illegal)
                        state_next = DONE;
                    else if (cpu.req_write && cpu.req_size == 2'b10)
                        state_next = WR_ISSUE;
                    else
                        state_next = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_next = RD_CAPTURE;
            RD_CAPTURE: state_next = store_q ? WR_ISSUE : DONE;
            WR_ISSUE:   state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Output decode. Everything is forced low while rst is high so that an
    // operation aborted by reset (notably in WR_ISSUE) never reaches the RAM.
    always_comb begin
        cpu.busy         = 1'b0;
        cpu.done         = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_data_in      = 32'h0;
        if (!rst) begin
            case (state)
                IDLE: cpu.busy = req_any;
                RD_ISSUE: begin
                    cpu.busy        = 1'b1;
                    ram_read_enable = 1'b1;
                    ram_address     = addr_q[ADDR_WIDTH+1:2];
                end
                RD_CAPTURE: begin
                    cpu.busy    = 1'b1;
                    ram_address = addr_q[ADDR_WIDTH+1:2];
                end
                WR_ISSUE: begin
                    cpu.busy         = 1'b1;
                    ram_write_enable = 1'b1;
                    ram_address      = addr_q[ADDR_WIDTH+1:2];
                    ram_data_in      = (size_q == 2'b10) ? wdata_q : merged_q;
                end
                DONE:    cpu.done = 1'b1;
                default: cpu.busy = 1'b0;
            endcase
        end
    end

    assign cpu.resp_rdata = resp_rdata_q;
    assign cpu.err        = err_q;

    // State register plus request capture and result registers. The result
    // is cleared on every accepted request so stores and errors report 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            wdata_q      <= 32'h0;
            merged_q     <= 32'h0;
            resp_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q       <= cpu.req_addr[ADDR_WIDTH+1:0];
                        size_q       <= cpu.req_size;
                        uns_q        <= cpu.req_unsigned;
                        store_q      <= cpu.req_write;
                        wdata_q      <= cpu.req_wdata;
                        resp_rdata_q <= 32'h0;
                        err_q        <= req_illegal;
                    end
                end
                RD_CAPTURE: begin
                    if (store_q)
                        merged_q <= merged_value;
                    else
                        resp_rdata_q <= load_value;
                end
                default: ;
            endcase
        end
    end

endmodule
